// File: rtl/tx_packet_arbiter.sv
// Round-robin arbiter sharing one UART byte stream among N_CH reply channels.
// Each grant emits PREFIX, source, destination, length, then the payload bytes.
module tx_packet_arbiter #(
    parameter int         N_CH      = 5,
    parameter logic [7:0] PREFIX    = 8'hDD,
    parameter logic [7:0] HOST_ADDR = 8'h01,
    parameter logic [7:0] SRC_BASE  = 8'h02
) (
    input  logic                fpga_clk_48,
    input  logic                rst,
    input  logic [N_CH-1:0]     req_bus,
    input  logic [N_CH*8-1:0]   len_bus,
    input  logic [N_CH*8-1:0]   data_bus,
    input  logic [N_CH-1:0]     valid_bus,
    output logic [N_CH-1:0]     ready_bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [N_CH-1:0]     grant,
    output logic [2:0]          my_state,
    output logic [7:0]          my_cnt
);

    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFIX  = 3'd1,
        S_SRC     = 3'd2,
        S_DEST    = 3'd3,
        S_LEN     = 3'd4,
        S_PAYLOAD = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   g_r, g_n, rr_ptr, rr_n, g_inc;
    logic [GW-1:0]   pick, pick_pos;
    logic            pick_vld;
    logic [7:0]      len_r, len_n, cnt_n, tx_data_n;
    logic            tx_valid_n;
    logic [N_CH-1:0] grant_n;
    logic            free, xfer, accept;
    logic [7:0]      len_arr  [N_CH];
    logic [7:0]      data_arr [N_CH];

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_unpack
            assign len_arr[i]  = len_bus[8*i +: 8];
            assign data_arr[i] = data_bus[8*i +: 8];
        end
    endgenerate

    assign free     = !tx_valid || tx_ready;
    assign xfer     = tx_valid && tx_ready;
    assign g_inc    = (g_r == GW'(N_CH-1)) ? '0 : GW'(g_r + 1'b1);
    assign my_state = state;

    // Scan from the lowest offset last so the first request at/after rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        pick_pos = '0;
        for (int k = N_CH-1; k >= 0; k--) begin
            pick_pos = GW'((int'(rr_ptr) + k) % N_CH);
            if (req_bus[pick_pos]) begin
                pick_vld = 1'b1;
                pick     = pick_pos;
            end
        end
    end

    always_comb begin
        ready_bus = '0;
        if (state == S_PAYLOAD && free && my_cnt < len_r)
            ready_bus[g_r] = 1'b1;
    end

    assign accept = valid_bus[g_r] && ready_bus[g_r];

    always_comb begin
        state_n    = state;
        g_n        = g_r;
        rr_n       = rr_ptr;
        len_n      = len_r;
        cnt_n      = my_cnt;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        grant_n    = grant;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    g_n        = pick;
                    grant_n    = '0;
                    grant_n[pick] = 1'b1;
                    len_n      = len_arr[pick];
                    cnt_n      = '0;
                    tx_data_n  = PREFIX;
                    tx_valid_n = 1'b1;
                    state_n    = S_PREFIX;
                end
            end
            S_PREFIX: if (xfer) begin
                tx_data_n = SRC_BASE + 8'(g_r);
                state_n   = S_SRC;
            end
            S_SRC: if (xfer) begin
                tx_data_n = HOST_ADDR;
                state_n   = S_DEST;
            end
            S_DEST: if (xfer) begin
                tx_data_n = len_r;
                state_n   = S_LEN;
            end
            S_LEN: if (xfer) begin
                tx_valid_n = 1'b0;
                if (len_r == 8'd0) begin
                    grant_n = '0;
                    rr_n    = g_inc;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // Last byte leaving the register closes the packet.
                if (my_cnt == len_r && xfer) begin
                    tx_valid_n = 1'b0;
                    grant_n    = '0;
                    rr_n       = g_inc;
                    state_n    = S_IDLE;
                end else if (accept) begin
                    tx_data_n  = data_arr[g_r];
                    tx_valid_n = 1'b1;
                    cnt_n      = my_cnt + 8'd1;
                end else if (free) begin
                    tx_valid_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk_48 or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            g_r      <= '0;
            rr_ptr   <= '0;
            len_r    <= '0;
            my_cnt   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            grant    <= '0;
        end else begin
            state    <= state_n;
            g_r      <= g_n;
            rr_ptr   <= rr_n;
            len_r    <= len_n;
            my_cnt   <= cnt_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            grant    <= grant_n;
        end
    end

endmodule

// File: doc/tx_packet_arbiter.md
Name: tx_packet_arbiter

Overview:
- Shares the single UART transmitter among N_CH internal channels, sending replies back to the host.
- Selects one pending channel by round-robin arbitration.
- Emits a framed packet on the tx byte stream: prefix, source address, destination address, length, then the payload bytes.
- Sits between the per-channel reply buffers (ready_bus/data_bus/valid_bus return side) and the uart_tx byte interface.

Parameters:
- N_CH, 5, number of requesting channels.
- PREFIX, 8'hDD, packet start byte.
- HOST_ADDR, 8'h01, destination address placed in every packet.
- SRC_BASE, 8'h02, source address of channel i is SRC_BASE+i (8-bit wrap).

Ports:
- fpga_clk_48  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_bus  in  N_CH  channel i has a complete packet pending.
- len_bus  in  N_CH*8  payload length of channel i, bits [8i+7:8i]; valid while req_bus[i]=1.
- data_bus  in  N_CH*8  payload byte of channel i.
- valid_bus  in  N_CH  payload byte valid, per channel.
- ready_bus  out  N_CH  payload byte accepted, per channel.
- tx_data  out  8  byte to uart_tx.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  uart_tx accepts the byte.
- grant  out  N_CH  one-hot current owner; 0 in IDLE.
- my_state  out  3  debug: encoded FSM state.
- my_cnt  out  8  debug: payload bytes accepted so far.

Behaviour:
- Reset (async, any time, including mid-packet): state=IDLE, tx_valid=0, tx_data=0, grant=0, ready_bus=0, my_cnt=0, rr pointer=0 (channel 0 highest priority). The interrupted packet is abandoned; no bytes are emitted after reset deasserts until a new grant.
- Output register:
  - tx_data/tx_valid are registered.
  - A byte is transferred on a cycle with tx_valid&&tx_ready.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - The register is "free" when !tx_valid || tx_ready.
- FSM states, encoded 0..5: IDLE, PREFIX, SRC, DEST, LEN, PAYLOAD.
- IDLE:
  - If req_bus != 0, pick the first set bit searching from the rr pointer upward with wrap.
  - Next cycle: grant=one-hot(g), latch len_bus[g] into len_r, my_cnt=0, state=PREFIX, tx_data=PREFIX, tx_valid=1.
  - Arbitration latency is exactly 1 cycle.
- PREFIX → SRC → DEST → LEN:
  - Each state advances on a transfer.
  - On the transfer, the register is loaded with the next header byte in the same cycle: SRC_BASE+g, HOST_ADDR, len_r. tx_valid stays 1, so there are no bubbles between header bytes.
- LEN state, on transfer:
  - len_r==0: tx_valid=0, grant=0, rr pointer=(g+1) mod N_CH, state=IDLE.
  - Otherwise: tx_valid=0, state=PAYLOAD.
- PAYLOAD:
  - ready_bus[g] = (state==PAYLOAD) && free && my_cnt<len_r. This is combinational; all other ready bits are 0.
  - On valid_bus[g]&&ready_bus[g]: tx_data<=data_bus[g], tx_valid<=1, my_cnt<=my_cnt+1.
  - If free and no byte is accepted, tx_valid<=0.
  - When my_cnt==len_r and the last byte has transferred: state=IDLE, grant=0, rr pointer=(g+1) mod N_CH, tx_valid=0.
  - Full throughput of 1 byte/cycle when tx_ready is held high.
- Requests and lengths:
  - req_bus/len_bus of the owner are sampled only at grant. Later changes to them are ignored until the packet ends.
  - A request dropped mid-packet does not abort the packet; the arbiter waits on valid_bus.
- Simultaneous events:
  - A new request arriving on the same cycle the FSM returns to IDLE is considered on the following IDLE cycle.
  - A back-to-back packet therefore has a 1-cycle gap with tx_valid=0.
- Widths: len and cnt are 8 bits, max 255 payload bytes; my_cnt never wraps.
- Valid bits from non-granted channels are ignored; their ready bit stays 0.

Test Plan:
- Single request: req_bus=5'b00100, len=3, payload 0A,0B,0C, tx_ready=1. Required: grant=00100 after 1 cycle; tx bytes DD,04,01,03,0A,0B,0C on consecutive transfers; return to IDLE; rr pointer=3.
- Round-robin fairness: req_bus=5'b10011 held, len=1 each. Required: packets issued in order ch0, ch1, ch4, ch0; source bytes 02,03,06,02.
- Backpressure: tx_ready toggled 1,0,0,1 during the header. Required: tx_data held stable while tx_ready=0; no byte lost or duplicated; ready_bus[g]=0 while the register is occupied.
- Zero length: ch1 with len=0. Required: exactly DD,03,01,00; ready_bus never asserted; IDLE after the LEN byte.
- Payload stall: valid_bus[g] low for 4 cycles mid-payload, len=6 (01..06). Required: tx_valid=0 during the gap; all 6 bytes emitted in order; my_cnt ends at 6.
- Reset mid-payload: assert rst after the 2nd payload byte. Required: tx_valid=0, grant=0, state=IDLE immediately (async); a fresh request afterwards starts with DD and rr pointer=0.
